// File: rtl/rect_flip_engine_pkg.sv
// Shared types and index helper for the rectangle flip engine.
// Matrix element (r,c) lives at bit N-1-(c*ROWS+r) of the packed matrix.
package rect_flip_engine_pkg;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_NOSWAP  = 2'd1,
        ST_INVALID = 2'd2
    } rsp_status_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        EVAL  = 2'd2,
        RESP  = 2'd3
    } state_e;

    function automatic int bit_idx(input int r, input int c, input int rows, input int n);
        return n - 1 - (c * rows + r);
    endfunction

endpackage

// File: rtl/rect_flip_engine_if.sv
// Load / command / response bus of the rectangle flip engine, plus matrix and counter taps.
interface rect_flip_engine_if #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int CNT_W = 16
);
    localparam int N  = ROWS * COLS;
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    logic                               load_valid;
    logic                               load_ready;
    logic [N-1:0]                       load_data;
    logic                               cmd_valid;
    logic                               cmd_ready;
    logic [RW-1:0]                      cmd_r1;
    logic [RW-1:0]                      cmd_r2;
    logic [CW-1:0]                      cmd_c1;
    logic [CW-1:0]                      cmd_c2;
    logic                               cmd_force;
    logic                               rsp_valid;
    logic                               rsp_ready;
    rect_flip_engine_pkg::rsp_status_e  rsp_status;
    logic [N-1:0]                       m_out;
    logic [CNT_W-1:0]                   swap_cnt;
    logic [CNT_W-1:0]                   reject_cnt;

    modport slave (
        input  load_valid, load_data, cmd_valid, cmd_r1, cmd_r2, cmd_c1, cmd_c2,
               cmd_force, rsp_ready,
        output load_ready, cmd_ready, rsp_valid, rsp_status, m_out, swap_cnt, reject_cnt
    );

    modport master (
        output load_valid, load_data, cmd_valid, cmd_r1, cmd_r2, cmd_c1, cmd_c2,
               cmd_force, rsp_ready,
        input  load_ready, cmd_ready, rsp_valid, rsp_status, m_out, swap_cnt, reject_cnt
    );

endinterface

// File: rtl/rect_flip_engine_corner_mask.sv
// Combinational rectangle decode: index validity, 4-corner flip mask and the corner values.
module rect_flip_engine_corner_mask
    import rect_flip_engine_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    localparam int N   = ROWS * COLS,
    localparam int RW  = $clog2(ROWS),
    localparam int CW  = $clog2(COLS)
) (
    input  logic [N-1:0]  i_matrix,
    input  logic [RW-1:0] i_r1,
    input  logic [RW-1:0] i_r2,
    input  logic [CW-1:0] i_c1,
    input  logic [CW-1:0] i_c2,
    output logic          o_idx_ok,
    output logic [N-1:0]  o_mask,
    output logic          o_a,
    output logic          o_b,
    output logic          o_c,
    output logic          o_d
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] w_ia, w_ib, w_ic, w_id;

    // NOTE: every output gets a default before the conditional writes, so no latch is inferred.
    always_comb begin
        w_ia = IW'(bit_idx(int'(i_r1), int'(i_c1), ROWS, N));
        w_ib = IW'(bit_idx(int'(i_r1), int'(i_c2), ROWS, N));
        w_ic = IW'(bit_idx(int'(i_r2), int'(i_c1), ROWS, N));
        w_id = IW'(bit_idx(int'(i_r2), int'(i_c2), ROWS, N));
        o_idx_ok = (i_r1 != i_r2) && (i_c1 != i_c2)
                && (int'(i_r1) < ROWS) && (int'(i_r2) < ROWS)
                && (int'(i_c1) < COLS) && (int'(i_c2) < COLS);
        o_mask = '0;
        o_a    = 1'b0;
        o_b    = 1'b0;
        o_c    = 1'b0;
        o_d    = 1'b0;
        if (o_idx_ok) begin
            o_mask[w_ia] = 1'b1;
            o_mask[w_ib] = 1'b1;
            o_mask[w_ic] = 1'b1;
            o_mask[w_id] = 1'b1;
            o_a = i_matrix[w_ia];
            o_b = i_matrix[w_ib];
            o_c = i_matrix[w_ic];
            o_d = i_matrix[w_id];
        end
    end

endmodule

// File: rtl/rect_flip_engine.sv
// Stateful rectangle-loop swap engine: matrix register, command FSM, response and
// saturating swap/reject counters around a combinational corner decoder.
module rect_flip_engine
    import rect_flip_engine_pkg::*;
#(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    rect_flip_engine_if.slave  bus
);
    localparam int N  = ROWS * COLS;
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           r_state;
    logic [N-1:0]     r_matrix;
    logic [RW-1:0]    r_r1, r_r2;
    logic [CW-1:0]    r_c1, r_c2;
    logic             r_force;
    rsp_status_e      r_rsp_status;
    logic             r_rsp_valid;
    logic             r_load_ready;
    logic             r_cmd_en;
    logic [CNT_W-1:0] r_swap_cnt;
    logic [CNT_W-1:0] r_reject_cnt;

    logic             w_idx_ok;
    logic [N-1:0]     w_mask;
    logic             w_a, w_b, w_c, w_d;
    logic             w_load_fire;
    logic             w_cmd_fire;
    rsp_status_e      w_status;

    rect_flip_engine_corner_mask #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_corner_mask (
        .i_matrix (r_matrix),
        .i_r1     (r_r1),
        .i_r2     (r_r2),
        .i_c1     (r_c1),
        .i_c2     (r_c2),
        .o_idx_ok (w_idx_ok),
        .o_mask   (w_mask),
        .o_a      (w_a),
        .o_b      (w_b),
        .o_c      (w_c),
        .o_d      (w_d)
    );

    // A pending load blocks command acceptance in the same cycle.
    assign bus.cmd_ready  = r_cmd_en & ~bus.load_valid;
    assign bus.load_ready = r_load_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_status = r_rsp_status;
    assign bus.m_out      = r_matrix;
    assign bus.swap_cnt   = r_swap_cnt;
    assign bus.reject_cnt = r_reject_cnt;

    assign w_load_fire = bus.load_valid & r_load_ready;
    assign w_cmd_fire  = bus.cmd_valid & bus.cmd_ready;

    always_comb begin
        if (!w_idx_ok)
            w_status = ST_INVALID;
        else if (r_force || ((w_a == w_d) && (w_b == w_c) && (w_a != w_b)))
            w_status = ST_OK;
        else
            w_status = ST_NOSWAP;
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_matrix     <= '0;
            r_r1         <= '0;
            r_r2         <= '0;
            r_c1         <= '0;
            r_c2         <= '0;
            r_force      <= 1'b0;
            r_rsp_status <= ST_OK;
            r_rsp_valid  <= 1'b0;
            r_load_ready <= 1'b1;
            r_cmd_en     <= 1'b0;
            r_swap_cnt   <= '0;
            r_reject_cnt <= '0;
        end else begin
            case (r_state)
                IDLE, READY: begin
                    if (w_load_fire) begin
                        r_matrix     <= bus.load_data;
                        r_swap_cnt   <= '0;
                        r_reject_cnt <= '0;
                        r_state      <= READY;
                        r_cmd_en     <= 1'b1;
                    end else if (w_cmd_fire) begin
                        r_r1         <= bus.cmd_r1;
                        r_r2         <= bus.cmd_r2;
                        r_c1         <= bus.cmd_c1;
                        r_c2         <= bus.cmd_c2;
                        r_force      <= bus.cmd_force;
                        r_state      <= EVAL;
                        r_load_ready <= 1'b0;
                        r_cmd_en     <= 1'b0;
                    end
                end
                EVAL: begin
                    r_rsp_status <= w_status;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= RESP;
                    if (w_status == ST_OK) begin
                        r_matrix <= r_matrix ^ w_mask;
                        if (r_swap_cnt != CNT_MAX)
                            r_swap_cnt <= r_swap_cnt + CNT_W'(1);
                    end else if (r_reject_cnt != CNT_MAX) begin
                        r_reject_cnt <= r_reject_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid  <= 1'b0;
                        r_state      <= READY;
                        r_load_ready <= 1'b1;
                        r_cmd_en     <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rect_flip_engine.sv
// Self-checking bench: directed vector table, random commands against a row/column-sum
// reference model, and hand sequences for backpressure, collision, reset and saturation.
module tb_rect_flip_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rect_flip_engine_if #(.ROWS(4), .COLS(4), .CNT_W(16)) mb ();
    rect_flip_engine_if #(.ROWS(3), .COLS(4), .CNT_W(2))  ab ();

    rect_flip_engine #(.ROWS(4), .COLS(4), .CNT_W(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mb)
    );

    rect_flip_engine #(.ROWS(3), .COLS(4), .CNT_W(2)) u_aux (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ab)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        bit          do_load;
        logic [15:0] load_val;
        int          r1, r2, c1, c2;
        bit          frc;
        logic [1:0]  exp_st;
        logic [15:0] exp_m;
        int          exp_swap, exp_rej;
    } vec_t;

    vec_t vec [9];

    bit ref_m [4][4];
    int ref_swap, ref_rej;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pack_ref();
        logic [15:0] v;
        v = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                v[15 - (c * 4 + r)] = ref_m[r][c];
        return v;
    endfunction

    function automatic void unpack_ref(input logic [15:0] v);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                ref_m[r][c] = v[15 - (c * 4 + r)];
    endfunction

    // Reference: flip is legal when every row and column sum survives it.
    function automatic logic [1:0] model_cmd(input int r1, input int r2, input int c1,
                                             input int c2, input bit f);
        bit t [4][4];
        bit sums_ok;
        int s0, s1;
        if (r1 == r2 || c1 == c2 || r1 > 3 || r2 > 3 || c1 > 3 || c2 > 3) begin
            ref_rej++;
            return 2'd2;
        end
        t = ref_m;
        t[r1][c1] = ~t[r1][c1];
        t[r1][c2] = ~t[r1][c2];
        t[r2][c1] = ~t[r2][c1];
        t[r2][c2] = ~t[r2][c2];
        sums_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s0 = 0; s1 = 0;
            for (int j = 0; j < 4; j++) begin s0 += int'(ref_m[i][j]); s1 += int'(t[i][j]); end
            if (s0 != s1) sums_ok = 1'b0;
            s0 = 0; s1 = 0;
            for (int j = 0; j < 4; j++) begin s0 += int'(ref_m[j][i]); s1 += int'(t[j][i]); end
            if (s0 != s1) sums_ok = 1'b0;
        end
        if (f || sums_ok) begin
            ref_m = t;
            ref_swap++;
            return 2'd0;
        end
        ref_rej++;
        return 2'd1;
    endfunction

    task automatic do_load(input logic [15:0] d);
        mb.load_data  = d;
        mb.load_valid = 1'b1;
        #1;
        for (int k = 0; k < 16 && !mb.load_ready; k++) tick();
        check("load_ready", 32'(mb.load_ready), 32'd1);
        tick();
        mb.load_valid = 1'b0;
    endtask

    task automatic do_cmd(input int r1, input int r2, input int c1, input int c2, input bit f,
                          output logic [1:0] st, output logic [15:0] m,
                          output logic [15:0] sc, output logic [15:0] rc);
        mb.cmd_r1    = 2'(r1);
        mb.cmd_r2    = 2'(r2);
        mb.cmd_c1    = 2'(c1);
        mb.cmd_c2    = 2'(c2);
        mb.cmd_force = f;
        mb.cmd_valid = 1'b1;
        #1;
        for (int k = 0; k < 16 && !mb.cmd_ready; k++) tick();
        check("cmd_ready", 32'(mb.cmd_ready), 32'd1);
        tick();
        mb.cmd_valid = 1'b0;
        mb.cmd_r1    = 2'($urandom);
        mb.cmd_r2    = 2'($urandom);
        mb.cmd_c1    = 2'($urandom);
        mb.cmd_c2    = 2'($urandom);
        mb.cmd_force = 1'($urandom);
        check("rsp_not_yet", 32'(mb.rsp_valid), 32'd0);
        tick();
        check("rsp_latency", 32'(mb.rsp_valid), 32'd1);
        st = mb.rsp_status;
        m  = mb.m_out;
        sc = mb.swap_cnt;
        rc = mb.reject_cnt;
        mb.rsp_ready = 1'b1;
        tick();
        mb.rsp_ready = 1'b0;
    endtask

    task automatic aux_load(input logic [11:0] d);
        ab.load_data  = d;
        ab.load_valid = 1'b1;
        #1;
        for (int k = 0; k < 16 && !ab.load_ready; k++) tick();
        check("aux_load_ready", 32'(ab.load_ready), 32'd1);
        tick();
        ab.load_valid = 1'b0;
    endtask

    task automatic aux_cmd(input int r1, input int r2, input int c1, input int c2, input bit f,
                           output logic [1:0] st, output logic [11:0] m,
                           output logic [1:0] sc, output logic [1:0] rc);
        ab.cmd_r1    = 2'(r1);
        ab.cmd_r2    = 2'(r2);
        ab.cmd_c1    = 2'(c1);
        ab.cmd_c2    = 2'(c2);
        ab.cmd_force = f;
        ab.cmd_valid = 1'b1;
        #1;
        for (int k = 0; k < 16 && !ab.cmd_ready; k++) tick();
        check("aux_cmd_ready", 32'(ab.cmd_ready), 32'd1);
        tick();
        ab.cmd_valid = 1'b0;
        for (int k = 0; k < 16 && !ab.rsp_valid; k++) tick();
        check("aux_rsp_valid", 32'(ab.rsp_valid), 32'd1);
        st = ab.rsp_status;
        m  = ab.m_out;
        sc = ab.swap_cnt;
        rc = ab.reject_cnt;
        ab.rsp_ready = 1'b1;
        tick();
        ab.rsp_ready = 1'b0;
    endtask

    initial begin
        logic [1:0]  st;
        logic [15:0] m, sc, rc;
        logic [11:0] am;
        logic [1:0]  asc, arc;
        logic [1:0]  exp_st;
        logic [15:0] d;
        int r1, r2, c1, c2;
        bit f;

        vec[0] = '{1'b1, 16'h8421, 0, 1, 0, 1, 1'b0, 2'd0, 16'h4821, 1, 0};
        vec[1] = '{1'b0, 16'h0000, 0, 1, 0, 1, 1'b0, 2'd0, 16'h8421, 2, 0};
        vec[2] = '{1'b1, 16'hFFFF, 0, 1, 0, 1, 1'b0, 2'd1, 16'hFFFF, 0, 1};
        vec[3] = '{1'b0, 16'h0000, 0, 1, 0, 1, 1'b1, 2'd0, 16'h33FF, 1, 1};
        vec[4] = '{1'b0, 16'h0000, 2, 2, 0, 3, 1'b0, 2'd2, 16'h33FF, 1, 2};
        vec[5] = '{1'b0, 16'h0000, 0, 3, 1, 1, 1'b1, 2'd2, 16'h33FF, 1, 3};
        vec[6] = '{1'b1, 16'h0000, 1, 2, 0, 1, 1'b0, 2'd1, 16'h0000, 0, 1};
        vec[7] = '{1'b0, 16'h0000, 1, 2, 0, 1, 1'b1, 2'd0, 16'h6600, 1, 1};
        vec[8] = '{1'b1, 16'h4821, 1, 0, 1, 0, 1'b0, 2'd0, 16'h8421, 1, 0};

        {mb.load_valid, mb.cmd_valid, mb.rsp_ready, mb.cmd_force} = '0;
        {mb.cmd_r1, mb.cmd_r2, mb.cmd_c1, mb.cmd_c2} = '0;
        mb.load_data = '0;
        {ab.load_valid, ab.cmd_valid, ab.rsp_ready, ab.cmd_force} = '0;
        {ab.cmd_r1, ab.cmd_r2, ab.cmd_c1, ab.cmd_c2} = '0;
        ab.load_data = '0;

        // Reset state
        tick();
        tick();
        mb.cmd_valid = 1'b1;
        #1;
        check("rst_m_out", 32'(mb.m_out), 32'd0);
        check("rst_rsp_valid", 32'(mb.rsp_valid), 32'd0);
        check("rst_cmd_ready", 32'(mb.cmd_ready), 32'd0);
        check("rst_load_ready", 32'(mb.load_ready), 32'd1);
        check("rst_swap_cnt", 32'(mb.swap_cnt), 32'd0);
        check("rst_reject_cnt", 32'(mb.reject_cnt), 32'd0);
        mb.cmd_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // Directed vectors
        for (int i = 0; i < 9; i++) begin
            if (vec[i].do_load) do_load(vec[i].load_val);
            do_cmd(vec[i].r1, vec[i].r2, vec[i].c1, vec[i].c2, vec[i].frc, st, m, sc, rc);
            check($sformatf("vec%0d_status", i), 32'(st), 32'(vec[i].exp_st));
            check($sformatf("vec%0d_m_out", i), 32'(m), 32'(vec[i].exp_m));
            check($sformatf("vec%0d_swap", i), 32'(sc), 32'(vec[i].exp_swap));
            check($sformatf("vec%0d_reject", i), 32'(rc), 32'(vec[i].exp_rej));
        end

        // Random commands against the reference model
        for (int i = 0; i < 80; i++) begin
            if (i % 16 == 0) begin
                d = 16'($urandom);
                do_load(d);
                unpack_ref(d);
                ref_swap = 0;
                ref_rej  = 0;
            end
            r1 = int'($urandom_range(0, 3));
            r2 = int'($urandom_range(0, 3));
            c1 = int'($urandom_range(0, 3));
            c2 = int'($urandom_range(0, 3));
            f  = ($urandom_range(0, 3) == 0);
            exp_st = model_cmd(r1, r2, c1, c2, f);
            do_cmd(r1, r2, c1, c2, f, st, m, sc, rc);
            check($sformatf("rnd%0d_status", i), 32'(st), 32'(exp_st));
            check($sformatf("rnd%0d_m_out", i), 32'(m), 32'(pack_ref()));
            check($sformatf("rnd%0d_swap", i), 32'(sc), 32'(ref_swap));
            check($sformatf("rnd%0d_reject", i), 32'(rc), 32'(ref_rej));
        end

        // Response backpressure: everything holds while rsp_ready is low
        do_load(16'h8421);
        mb.cmd_r1 = 2'd0; mb.cmd_r2 = 2'd1; mb.cmd_c1 = 2'd0; mb.cmd_c2 = 2'd1;
        mb.cmd_force = 1'b0;
        mb.cmd_valid = 1'b1;
        tick();
        mb.cmd_valid = 1'b0;
        tick();
        mb.cmd_valid  = 1'b1;
        mb.load_valid = 1'b1;
        mb.load_data  = 16'h0F0F;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_rsp_valid", 32'(mb.rsp_valid), 32'd1);
            check("bp_status", 32'(mb.rsp_status), 32'd0);
            check("bp_cmd_ready", 32'(mb.cmd_ready), 32'd0);
            check("bp_load_ready", 32'(mb.load_ready), 32'd0);
            tick();
        end
        check("bp_m_out", 32'(mb.m_out), 32'h4821);
        check("bp_swap", 32'(mb.swap_cnt), 32'd1);
        mb.cmd_valid  = 1'b0;
        mb.load_valid = 1'b0;
        mb.rsp_ready  = 1'b1;
        tick();
        mb.rsp_ready = 1'b0;
        mb.cmd_valid = 1'b1;
        #1;
        check("bp_rel_rsp_valid", 32'(mb.rsp_valid), 32'd0);
        check("bp_rel_load_ready", 32'(mb.load_ready), 32'd1);
        check("bp_rel_cmd_ready", 32'(mb.cmd_ready), 32'd1);
        mb.cmd_valid = 1'b0;

        // Load/command collision in READY: load wins
        mb.load_valid = 1'b1;
        mb.load_data  = 16'hA5A5;
        mb.cmd_valid  = 1'b1;
        mb.cmd_force  = 1'b1;
        #1;
        check("col_cmd_ready", 32'(mb.cmd_ready), 32'd0);
        check("col_load_ready", 32'(mb.load_ready), 32'd1);
        tick();
        mb.load_valid = 1'b0;
        mb.cmd_valid  = 1'b0;
        check("col_m_out", 32'(mb.m_out), 32'hA5A5);
        check("col_swap_clr", 32'(mb.swap_cnt), 32'd0);
        tick();
        tick();
        check("col_no_rsp", 32'(mb.rsp_valid), 32'd0);
        check("col_m_hold", 32'(mb.m_out), 32'hA5A5);

        // Reset while in EVAL
        do_cmd(0, 1, 0, 1, 1'b1, st, m, sc, rc);
        check("pre_rst_swap", 32'(sc), 32'd1);
        mb.cmd_r1 = 2'd2; mb.cmd_r2 = 2'd3; mb.cmd_c1 = 2'd2; mb.cmd_c2 = 2'd3;
        mb.cmd_force = 1'b1;
        mb.cmd_valid = 1'b1;
        tick();
        mb.cmd_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        mb.cmd_valid = 1'b1;
        #1;
        check("eval_rst_m_out", 32'(mb.m_out), 32'd0);
        check("eval_rst_swap", 32'(mb.swap_cnt), 32'd0);
        check("eval_rst_reject", 32'(mb.reject_cnt), 32'd0);
        check("eval_rst_rsp_valid", 32'(mb.rsp_valid), 32'd0);
        check("eval_rst_cmd_ready", 32'(mb.cmd_ready), 32'd0);
        check("eval_rst_load_ready", 32'(mb.load_ready), 32'd1);
        mb.cmd_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // ROWS=3 index range and CNT_W=2 saturation
        aux_load(12'h000);
        aux_cmd(3, 1, 0, 1, 1'b1, st, am, asc, arc);
        check("aux_r3_status", 32'(st), 32'd2);
        check("aux_r3_m_out", 32'(am), 32'h000);
        check("aux_r3_reject", 32'(arc), 32'd1);
        for (int k = 0; k < 5; k++) begin
            aux_cmd(0, 1, 0, 1, 1'b1, st, am, asc, arc);
            check($sformatf("aux_sat%0d_status", k), 32'(st), 32'd0);
            check($sformatf("aux_sat%0d_swap", k), 32'(asc), (k < 2) ? 32'(k + 1) : 32'd3);
        end
        check("aux_sat_m_out", 32'(am), 32'hD80);
        check("aux_sat_reject", 32'(arc), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
